// File: rtl/wb_lsu_master.sv
// wb_lsu_master: memory-stage load/store unit, pipelined Wishbone initiator.
// One RV32I load/store at a time. Builds byte lanes, replicates store data,
// formats load data, and reports misaligned/illegal accesses without a bus cycle.
// Optional feature macro: WB_TIMEOUT_EN (ack timeout of TIMEOUT_CYCLES cycles).
//
// Handshake: a request is taken on the clock edge where req_valid && req_ready;
// the bus strobe is taken on the edge where wb_stb && !wb_stall; the response is
// a single-cycle resp_valid pulse with no backpressure.
module wb_lsu_master #(
  parameter int ADDR_WIDTH = 10
`ifdef WB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 15
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  busy,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  output logic                  wb_wr_en,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [31:0]           wb_wr_data,
  output logic [3:0]            wb_sel,
  input  logic                  wb_ack,
  input  logic                  wb_stall,
  input  logic [31:0]           wb_rd_data,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, STB = 2'd1, ACK = 2'd2} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            sel_q;
  logic [2:0]            funct3_q;
  logic                  store_q;

  logic                  req_legal;
  logic [3:0]            req_sel;
  logic [31:0]           req_wdata_rep;
  logic                  start;
  logic                  done_ok;
  logic                  done_err;
  logic [31:0]           rd_shift;
  logic [31:0]           load_data;

  // Address bits above the bus width are dropped (address wraps).
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH];

  // Decode legality, byte lanes and lane-replicated store data of the request.
  always_comb begin
    req_legal     = 1'b0;
    req_sel       = 4'b1111;
    req_wdata_rep = req_wdata;
    if (req_is_store) begin
      req_legal = (req_funct3 <= 3'b010);
      case (req_funct3[1:0])
        2'b00:   begin
          req_sel       = 4'b0001 << req_addr[1:0];
          req_wdata_rep = {4{req_wdata[7:0]}};
        end
        2'b01:   begin
          req_sel       = req_addr[1] ? 4'b1100 : 4'b0011;
          req_wdata_rep = {2{req_wdata[15:0]}};
        end
        default: ;
      endcase
    end else begin
      req_legal = (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end
    if (req_funct3[1:0] == 2'b01 && req_addr[0]) req_legal = 1'b0;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) req_legal = 1'b0;
  end

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             timeout_hit;
  assign timeout_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count cycles spent on the bus; cleared at the start of every access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              tmo_cnt <= '0;
    else if (start)          tmo_cnt <= '0;
    else if (state != IDLE)  tmo_cnt <= tmo_cnt + 1'b1;
  end
`endif

  // Next-state and completion decode.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    done_ok    = 1'b0;
    done_err   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_legal) begin
            start      = 1'b1;
            state_next = STB;
          end else begin
            done_err = 1'b1;
          end
        end
      end
      STB: begin
        if (!wb_stall) begin
          if (wb_ack) begin
            done_ok    = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = ACK;
          end
        end
      end
      ACK: begin
        if (wb_ack) begin
          done_ok    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
`ifdef WB_TIMEOUT_EN
    if (state != IDLE && !done_ok && timeout_hit) begin
      done_err   = 1'b1;
      state_next = IDLE;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Latch the accepted request; bus outputs stay stable for the whole access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      sel_q    <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
    end else if (start) begin
      addr_q   <= req_addr[ADDR_WIDTH-1:0];
      wdata_q  <= req_wdata_rep;
      sel_q    <= req_sel;
      funct3_q <= req_funct3;
      store_q  <= req_is_store;
    end
  end

  // Pick the addressed lane and extend it according to the load type.
  always_comb begin
    rd_shift  = wb_rd_data >> {addr_q[1:0], 3'b000};
    load_data = wb_rd_data;
    case (funct3_q)
      3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_data = {24'd0, rd_shift[7:0]};
      3'b101:  load_data = {16'd0, rd_shift[15:0]};
      default: load_data = wb_rd_data;
    endcase
  end

  // One-cycle response pulse following completion or rejection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= done_ok | done_err;
      resp_err   <= done_err;
      resp_rdata <= (done_ok && !store_q) ? load_data : 32'd0;
    end
  end

  assign req_ready  = (state == IDLE);
  assign busy       = !req_ready;
  assign wb_cyc     = (state != IDLE);
  assign wb_stb     = (state == STB);
  assign wb_wr_en   = wb_cyc & store_q;
  assign wb_addr    = wb_cyc ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign wb_sel     = wb_cyc ? sel_q : 4'b0000;
  assign wb_wr_data = wb_cyc ? wdata_q : 32'd0;
  assign state_dbg  = state;

endmodule

// File: doc/wb_lsu_master.md
Name: wb_lsu_master

Overview:
Memory-stage load/store unit acting as the Wishbone initiator toward the unified main memory's data port. It takes one RV32I load/store request at a time from stage 4 and issues a single pipelined-Wishbone access. It generates byte lanes and replicated write data, formats load data with sign or zero extension, and holds the pipeline busy until the access completes. Misaligned and illegal accesses are rejected without a bus cycle.

Parameters:
ADDR_WIDTH, 10, byte-address width driven on wb_addr; must match the memory's ADDR_WIDTH.
TIMEOUT_CYCLES, 15, maximum cycles to wait for wb_ack; used only when WB_TIMEOUT_EN is defined.

Ports:
clk  in  1  single clock; all logic on posedge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  stage 4 presents a load/store.
req_ready  out  1  high in IDLE; a request is accepted on the edge where req_valid && req_ready.
req_is_store  in  1  1 = store, 0 = load.
req_funct3  in  3  RV32I funct3: LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010.
req_addr  in  32  byte address.
req_wdata  in  32  store data from rs2.
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  32  formatted load result; 0 for stores and errors.
resp_err  out  1  valid with resp_valid: misaligned, illegal funct3, or timeout.
busy  out  1  equals !req_ready; drives the pipeline stall.
wb_cyc  out  1  Wishbone cycle.
wb_stb  out  1  Wishbone strobe.
wb_wr_en  out  1  Wishbone write enable.
wb_addr  out  ADDR_WIDTH  word-aligned byte address: req_addr[ADDR_WIDTH-1:2],2'b00.
wb_wr_data  out  32  lane-replicated store data.
wb_sel  out  4  byte-lane select.
wb_ack  in  1  slave acknowledge.
wb_stall  in  1  slave stall; the strobe is accepted when wb_stb && !wb_stall.
wb_rd_data  in  32  slave read data, valid with wb_ack.

Behaviour:
- Reset values (asynchronous): state=IDLE; all outputs 0 except req_ready=1. Asserting reset mid-transaction drops wb_cyc/wb_stb immediately and produces no response.
- FSM states: IDLE, STB, ACK.
- IDLE, on accept:
  - Legal request: latch address, data, sel, funct3 and store flag into registers, go to STB. wb_cyc=wb_stb=1 from the next cycle.
  - Illegal request: stay in IDLE and pulse resp_valid=1, resp_err=1 next cycle; no bus activity.
  - Illegal means: misaligned halfword (addr[0]=1), misaligned word (addr[1:0]!=0), load funct3 in {011,110,111}, or store funct3 >010.
- STB: hold wb_stb and all bus outputs stable while wb_stall=1.
  - wb_stall=0 and wb_ack=0: drop wb_stb, go to ACK.
  - wb_stall=0 and wb_ack=1: complete directly.
- ACK: wb_cyc=1, wb_stb=0; wait for wb_ack.
- Complete: drop wb_cyc, return to IDLE. resp_valid pulses for one cycle after the ack edge with resp_err=0.
  - A new request is accepted in the same cycle resp_valid is high.
- Latency against the one-cycle-ack memory: accept at edge E0; stb high during E0→E1; ack high during E1→E2; resp_valid high during E2→E3. At most one outstanding access.
- Store lanes:
  - SB: sel = 4'b0001<<addr[1:0], data = {4{wdata[7:0]}}.
  - SH: sel = addr[1]?1100:0011, data = {2{wdata[15:0]}}.
  - SW: sel = 1111, data = wdata.
- Loads: wb_sel=1111. Select lane by the latched addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- req_addr bits above ADDR_WIDTH-1 are ignored (address wraps).
- A stray wb_ack in IDLE is ignored.

Optional Feature:
WB_TIMEOUT_EN:
- Defined: a counter starts at stb assertion. If no wb_ack after TIMEOUT_CYCLES cycles, drop wb_cyc/wb_stb, return to IDLE, and pulse resp_valid with resp_err=1, resp_rdata=0. The counter resets on every new access.
- Undefined: the block waits indefinitely for wb_ack; no counter logic.

Test Plan:
1. Memory word 0x10=0xDEADBEEF; LW addr 0x10 -> wb_addr=0x010, wb_sel=1111, wb_wr_en=0; resp_valid exactly 3 edges after accept with resp_rdata=0xDEADBEEF, resp_err=0.
2. SB addr 0x13, wdata 0x000000A5 -> wb_sel=1000, wb_wr_data=0xA5A5A5A5, wb_wr_en=1. Then LB 0x13 -> 0xFFFFFFA5; LBU 0x13 -> 0x000000A5.
3. SH addr 0x12, wdata 0x00008001 -> wb_sel=1100, wb_wr_data=0x80018001. Then LH 0x12 -> 0xFFFF8001; LHU -> 0x00008001.
4. LH addr 0x01 and SW addr 0x06 -> no wb_cyc; resp_valid=1, resp_err=1 the cycle after accept. Load funct3=011 -> same.
5. wb_stall held 3 cycles -> wb_stb and bus outputs held stable for 3 cycles, busy=1; completes normally afterwards. Back-to-back request accepted in the resp_valid cycle.
6. rst_n low while in ACK -> wb_cyc=0 immediately, no resp_valid. With WB_TIMEOUT_EN and the slave never acking -> resp_err=1 after 15 cycles.
